// File: rtl/i2c_shift_engine.sv
// I2C master frame shift engine: parallel-loads address/data frames for TX,
// assembles received frames, and tracks bit position, completion and busy state.
module i2c_shift_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter int unsigned CW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [9:0]            bus_address,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            shift_input_select,
    input  logic                  data_direction,
    input  logic                  shift_direction,
    input  logic                  shift_strobe,
    input  logic                  shift_in,
    input  logic                  shift_load,
    output logic                  shift_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CW-1:0]         bit_count,
    output logic                  byte_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TX_ACTIVE = 2'd1,
        RX_ACTIVE = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CW-1:0]         bit_count_q, bit_count_d;
    logic                  byte_done_q, byte_done_d;

    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [DATA_WIDTH-1:0] rx_shifted;
    logic [CW-1:0]         bit_count_inc;

    // Address frames sit in the top byte; any extra low bits load as 0.
    always_comb begin
        load_word = '0;
        unique case (shift_input_select)
            2'd0: load_word[DATA_WIDTH-1 -: 8] = {5'b11110, bus_address[9:8], data_direction};
            2'd1: load_word[DATA_WIDTH-1 -: 8] = bus_address[7:0];
            2'd2: load_word[DATA_WIDTH-1 -: 8] = {bus_address[6:0], data_direction};
            2'd3: load_word = tx_data;
        endcase
    end

    // TX shifts toward the output end and back-fills 1s so SDA ends released;
    // RX enters at the opposite end so the first bit lands in the first-bit slot.
    always_comb begin
        if (LSB_FIRST) begin
            tx_shifted = {1'b1, sreg_q[DATA_WIDTH-1:1]};
            rx_shifted = {shift_in, sreg_q[DATA_WIDTH-1:1]};
        end else begin
            tx_shifted = {sreg_q[DATA_WIDTH-2:0], 1'b1};
            rx_shifted = {sreg_q[DATA_WIDTH-2:0], shift_in};
        end
    end

    assign bit_count_inc = bit_count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        data_out_d  = data_out_q;
        bit_count_d = bit_count_q;
        byte_done_d = 1'b0;

        if (shift_load) begin
            sreg_d      = load_word;
            bit_count_d = '0;
            state_d     = TX_ACTIVE;
        end else if (shift_strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (shift_direction) begin
                        sreg_d      = rx_shifted;
                        bit_count_d = CW'(1);
                        state_d     = RX_ACTIVE;
                    end
                end
                TX_ACTIVE: begin
                    sreg_d      = tx_shifted;
                    bit_count_d = bit_count_inc;
                    if (bit_count_inc == FULL_COUNT) begin
                        state_d     = IDLE;
                        byte_done_d = 1'b1;
                    end
                end
                RX_ACTIVE: begin
                    bit_count_d = bit_count_inc;
                    if (bit_count_inc == FULL_COUNT) begin
                        data_out_d  = rx_shifted;
                        sreg_d      = '1;
                        state_d     = IDLE;
                        byte_done_d = 1'b1;
                    end else begin
                        sreg_d = rx_shifted;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            sreg_q      <= '1;
            data_out_q  <= '0;
            bit_count_q <= '0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            data_out_q  <= data_out_d;
            bit_count_q <= bit_count_d;
            byte_done_q <= byte_done_d;
        end
    end

    // SDA stays released while receiving so the slave can drive it.
    always_comb begin
        if (state_q == RX_ACTIVE) begin
            shift_out = 1'b1;
        end else if (LSB_FIRST) begin
            shift_out = sreg_q[0];
        end else begin
            shift_out = sreg_q[DATA_WIDTH-1];
        end
    end

    assign data_out  = data_out_q;
    assign bit_count = bit_count_q;
    assign byte_done = byte_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_shift_engine.sv
// Bench for i2c_shift_engine: MSB-first and LSB-first builds driven in parallel
// against a frame-level reference model (bit streams and assembled words).
module tb_i2c_shift_engine;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic [9:0]    bus_address;
    logic [DW-1:0] tx_data;
    logic [1:0]    sel;
    logic          data_direction, shift_direction, shift_strobe, shift_in, shift_load;

    logic          so_m, bd_m, busy_m;
    logic [DW-1:0] do_m;
    logic [CW-1:0] bc_m;
    logic          so_l, bd_l, busy_l;
    logic [DW-1:0] do_l;
    logic [CW-1:0] bc_l;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_do_m = '0;
    logic [DW-1:0] exp_do_l = '0;

    always #5 clk = ~clk;

    i2c_shift_engine #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .n_rst(n_rst), .bus_address(bus_address), .tx_data(tx_data),
        .shift_input_select(sel), .data_direction(data_direction),
        .shift_direction(shift_direction), .shift_strobe(shift_strobe),
        .shift_in(shift_in), .shift_load(shift_load), .shift_out(so_m),
        .data_out(do_m), .bit_count(bc_m), .byte_done(bd_m), .busy(busy_m)
    );

    i2c_shift_engine #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .bus_address(bus_address), .tx_data(tx_data),
        .shift_input_select(sel), .data_direction(data_direction),
        .shift_direction(shift_direction), .shift_strobe(shift_strobe),
        .shift_in(shift_in), .shift_load(shift_load), .shift_out(so_l),
        .data_out(do_l), .bit_count(bc_l), .byte_done(bd_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame contents straight from the load-source table.
    function automatic logic [DW-1:0] frame_of(input logic [1:0] s, input logic [9:0] a,
                                               input logic dd, input logic [DW-1:0] td);
        case (s)
            2'd0:    return {5'b11110, a[9:8], dd};
            2'd1:    return a[7:0];
            2'd2:    return {a[6:0], dd};
            default: return td;
        endcase
    endfunction

    task automatic check_both_idle(input string tag, input int count);
        chk({tag, "_so_m"}, 32'(so_m), 32'd1);
        chk({tag, "_so_l"}, 32'(so_l), 32'd1);
        chk({tag, "_busy_m"}, 32'(busy_m), 32'd0);
        chk({tag, "_busy_l"}, 32'(busy_l), 32'd0);
        chk({tag, "_bd_m"}, 32'(bd_m), 32'd0);
        chk({tag, "_bd_l"}, 32'(bd_l), 32'd0);
        chk({tag, "_bc_m"}, 32'(bc_m), 32'(count));
        chk({tag, "_bc_l"}, 32'(bc_l), 32'(count));
        chk({tag, "_do_m"}, 32'(do_m), 32'(exp_do_m));
        chk({tag, "_do_l"}, 32'(do_l), 32'(exp_do_l));
    endtask

    task automatic tx_frame(input logic [1:0] s, input logic [9:0] a, input logic dd,
                            input logic [DW-1:0] td, input bit coincident, input bit b2b);
        logic [DW-1:0] frame;
        frame = frame_of(s, a, dd, td);
        bus_address = a; sel = s; data_direction = dd; tx_data = td;
        shift_direction = 1'($urandom);
        shift_load = 1'b1; shift_strobe = coincident;
        tick();
        shift_load = 1'b0; shift_strobe = 1'b0;
        bus_address = 10'($urandom); tx_data = DW'($urandom);
        chk("tx_load_bc_m", 32'(bc_m), 32'd0);
        chk("tx_load_bc_l", 32'(bc_l), 32'd0);
        chk("tx_load_busy", 32'(busy_m), 32'd1);
        chk("tx_load_bd", 32'(bd_m), 32'd0);
        for (int i = 0; i < DW; i++) begin
            chk($sformatf("tx_bit%0d_m", i), 32'(so_m), 32'(frame[DW-1-i]));
            chk($sformatf("tx_bit%0d_l", i), 32'(so_l), 32'(frame[i]));
            shift_direction = 1'($urandom);
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            if (i < DW - 1) begin
                chk("tx_mid_bc", 32'(bc_m), 32'(i + 1));
                chk("tx_mid_bd", 32'(bd_m), 32'd0);
                chk("tx_mid_busy", 32'(busy_l), 32'd1);
                repeat ($urandom_range(0, 3)) tick();
            end else begin
                chk("tx_end_bd_m", 32'(bd_m), 32'd1);
                chk("tx_end_bd_l", 32'(bd_l), 32'd1);
                chk("tx_end_busy", 32'(busy_m), 32'd0);
                chk("tx_end_bc", 32'(bc_m), 32'(DW));
                chk("tx_end_so_m", 32'(so_m), 32'd1);
                chk("tx_end_so_l", 32'(so_l), 32'd1);
            end
        end
        if (!b2b) begin
            tick();
            check_both_idle("tx_after", DW);
        end
        $display("TX sel=%0d frame=0x%02h coincident=%0d b2b=%0d", s, frame, coincident, b2b);
    endtask

    task automatic rx_frame(input logic [DW-1:0] stream_word, input bit b2b);
        // stream_word[DW-1] is the first bit on the wire
        logic stream[DW];
        for (int i = 0; i < DW; i++) stream[i] = stream_word[DW-1-i];
        shift_direction = 1'b1;
        for (int i = 0; i < DW; i++) begin
            shift_in = stream[i];
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            shift_in = 1'($urandom);
            shift_direction = 1'($urandom);
            chk("rx_so_m", 32'(so_m), 32'd1);
            chk("rx_so_l", 32'(so_l), 32'd1);
            chk("rx_bc", 32'(bc_l), 32'(i + 1));
            if (i < DW - 1) begin
                chk("rx_mid_bd", 32'(bd_m), 32'd0);
                chk("rx_mid_busy", 32'(busy_m), 32'd1);
                chk("rx_mid_do", 32'(do_m), 32'(exp_do_m));
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        for (int i = 0; i < DW; i++) begin
            exp_do_m[DW-1-i] = stream[i];
            exp_do_l[i]      = stream[i];
        end
        chk("rx_end_bd_m", 32'(bd_m), 32'd1);
        chk("rx_end_bd_l", 32'(bd_l), 32'd1);
        chk("rx_end_busy", 32'(busy_l), 32'd0);
        chk("rx_end_do_m", 32'(do_m), 32'(exp_do_m));
        chk("rx_end_do_l", 32'(do_l), 32'(exp_do_l));
        if (!b2b) begin
            tick();
            check_both_idle("rx_after", DW);
        end
        $display("RX stream=0x%02h data_out_msb=0x%02h data_out_lsb=0x%02h b2b=%0d",
                 stream_word, exp_do_m, exp_do_l, b2b);
    endtask

    task automatic rx_partial(input int n);
        shift_direction = 1'b1;
        for (int i = 0; i < n; i++) begin
            shift_in = 1'($urandom);
            shift_strobe = 1'b1;
            tick();
            shift_strobe = 1'b0;
            tick();
        end
        chk("rx_part_bc", 32'(bc_m), 32'(n));
        chk("rx_part_busy", 32'(busy_m), 32'd1);
    endtask

    initial begin
        n_rst = 1'b0;
        bus_address = '0; tx_data = '0; sel = '0; data_direction = 1'b0;
        shift_direction = 1'b0; shift_strobe = 1'b0; shift_in = 1'b0; shift_load = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        check_both_idle("reset", 0);
        $display("RESET released");

        tx_frame(2'd0, 10'b1111100000, 1'b0, 8'h00, 1'b0, 1'b0);
        tx_frame(2'd2, 10'b1111100000, 1'b1, 8'h00, 1'b0, 1'b0);
        tx_frame(2'd1, 10'b1111100000, 1'b1, 8'h00, 1'b0, 1'b0);
        tx_frame(2'd3, 10'b1111100000, 1'b0, 8'h0F, 1'b0, 1'b0);

        shift_direction = 1'b0;
        shift_strobe = 1'b1;
        tick();
        shift_strobe = 1'b0;
        check_both_idle("idle_tx_strobe", DW);
        $display("IDLE strobe with TX direction ignored");

        rx_frame(8'hAA, 1'b0);
        tx_frame(2'd3, 10'($urandom), 1'b0, 8'h5A, 1'b0, 1'b0);
        tx_frame(2'd3, 10'h000, 1'b0, 8'hA5, 1'b1, 1'b0);

        rx_partial(3);
        tx_frame(2'd3, 10'h000, 1'b0, 8'h3C, 1'b0, 1'b0);
        $display("RX aborted by load, data_out kept 0x%02h", exp_do_m);

        rx_partial(3);
        #2;
        n_rst = 1'b0;
        #1;
        exp_do_m = '0; exp_do_l = '0;
        check_both_idle("async_reset", 0);
        tick();
        n_rst = 1'b1;
        repeat (2) begin
            tick();
            check_both_idle("post_reset", 0);
        end
        $display("RESET mid-RX after 3 strobes");

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1)
                tx_frame(2'($urandom), 10'($urandom), 1'($urandom), DW'($urandom),
                         1'($urandom), 1'($urandom));
            else
                rx_frame(DW'($urandom), 1'($urandom));
        end
        tick();
        check_both_idle("final", DW);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_shift_engine.md
Name: i2c_shift_engine

Overview:
- Parametrised successor to the I2C master byte shift register.
- Loads one frame from one of four sources (10-bit address bytes 1/2, 7-bit address, TX data), or shifts in a received frame.
- Adds selectable bit order, an internal bit counter, a frame-done pulse and a busy flag, so the master FSM no longer counts bits itself.
- Sits between the master control FSM (which drives strobes from SCL timing) and the SDA driver/sampler.

Parameters:
- DATA_WIDTH, 8: frame width in bits; must be >= 8. Address frames occupy bits [DATA_WIDTH-1:DATA_WIDTH-8]; any lower bits load 0.
- LSB_FIRST, 0: 0 = MSB shifted first (I2C standard); 1 = LSB first. Applies to both TX and RX.
- CW, $clog2(DATA_WIDTH+1): bit counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- bus_address  in  10  target address; 7-bit mode uses [6:0]
- tx_data  in  DATA_WIDTH  byte from TX FIFO
- shift_input_select  in  2  load source: 0 = 10-bit addr byte 1, 1 = 10-bit addr byte 2, 2 = 7-bit addr, 3 = tx_data
- data_direction  in  1  transaction R/W (0 = TX/write, 1 = RX/read); supplies the R/W bit
- shift_direction  in  1  frame direction (0 = TX, 1 = RX); latched at frame start
- shift_strobe  in  1  one-cycle shift request
- shift_in  in  1  sampled SDA
- shift_load  in  1  one-cycle parallel-load request
- shift_out  out  1  bit to drive on SDA (1 = released)
- data_out  out  DATA_WIDTH  last completed RX frame
- bit_count  out  CW  bits shifted in the current frame
- byte_done  out  1  one-cycle pulse when a frame completes
- busy  out  1  frame in progress

Behaviour:
- Reset (async, n_rst=0): sreg = all 1s, so shift_out = 1. data_out = 0, bit_count = 0, byte_done = 0, busy = 0, state = IDLE, latched direction = TX. A reset mid-frame aborts the frame immediately.
- States:
  - IDLE: busy = 0.
  - TX_ACTIVE and RX_ACTIVE: busy = 1.
- Load sources, for DATA_WIDTH = 8:
  - sel 0: {5'b11110, bus_address[9:8], data_direction}
  - sel 1: bus_address[7:0]
  - sel 2: {bus_address[6:0], data_direction}
  - sel 3: tx_data
- shift_load = 1 in any state:
  - next edge: sreg <= source, bit_count <= 0, state <= TX_ACTIVE, byte_done <= 0.
  - Load wins over a coincident strobe; that strobe is dropped.
  - A load during RX_ACTIVE aborts the RX frame and leaves data_out unchanged.
- shift_out output:
  - Combinational from sreg only: sreg[DATA_WIDTH-1] when LSB_FIRST = 0, else sreg[0].
  - First bit is valid the cycle after the load edge.
  - Forced to 1 in RX_ACTIVE.
- TX_ACTIVE, on strobe:
  - sreg shifts toward the output end, filling the vacated end with 1; bit_count increments.
  - On the strobe that brings bit_count to DATA_WIDTH: byte_done = 1 for exactly the next cycle, state returns to IDLE, busy = 0.
  - sreg is then all 1s, so shift_out = 1 and SDA is released for ACK.
  - bit_count holds DATA_WIDTH until the next load or frame start.
- IDLE, strobe with shift_direction = 1:
  - starts an RX frame: latch RX, bit_count <= 1, shift shift_in into the input end, state <= RX_ACTIVE.
  - Input end is sreg[0] when MSB-first, sreg[DATA_WIDTH-1] when LSB-first.
- RX_ACTIVE, on strobe:
  - shift in shift_in; bit_count increments.
  - On reaching DATA_WIDTH, on the same edge: data_out <= assembled word, byte_done pulses the next cycle, state <= IDLE, sreg <= all 1s.
- IDLE, strobe with shift_direction = 0: ignored; no state or counter change.
- shift_direction changes mid-frame: ignored until the next frame start.
- byte_done never stays high more than one cycle. Back-to-back frames may load on the cycle byte_done is high.
- No combinational path from inputs to outputs except through sreg.

Test Plan:
- Reset held for 2 cycles, then release -> shift_out = 1, data_out = 0x00, bit_count = 0, busy = 0, byte_done = 0.
- bus_address = 10'b1111100000, data_direction = TX, sel 0, load, then 8 strobes spaced 4 cycles apart:
  - shift_out before each strobe = 1,1,1,1,0,1,1,0 (frame 0xF6);
  - byte_done pulses once after the 8th strobe; busy falls; shift_out = 1.
- Same bus_address, data_direction = RX, sel 2 -> frame 0xC1, shift_out = 1,1,0,0,0,0,0,1. sel 1 -> frame 0xE0.
- tx_data = 0x0F, sel 3, LSB_FIRST = 1 build -> shift_out = 1,1,1,1,0,0,0,0.
- RX, shift_in stream 1,0,1,0,1,0,1,0 with LSB_FIRST = 0:
  - data_out = 0xAA after the 8th strobe; byte_done pulses once;
  - shift_out = 1 throughout; data_out holds 0xAA through a following TX frame.
- Boundary cases:
  - load and strobe on the same cycle -> bit_count = 0, first bit unshifted;
  - n_rst asserted after 3 RX strobes -> immediate reset values, no byte_done;
  - strobe in IDLE with TX direction -> no change.
